// File: rtl/bool_chk_pkg.sv
// Shared types and sizing for the Boolean response checker.
package bool_chk_pkg;

    localparam int unsigned VEC_W   = 5;
    localparam int unsigned NUM_VEC = 32;
    localparam int unsigned ERR_W   = 6;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bool_chk_sync2.sv
// Two-flop synchroniser for the Fout return path; both stages reset to 0.
module bool_chk_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bool_response_checker.sv
// Sweeps all 32 vectors of a 5-input function, compares Fout against EXPECTED_TT.
// Define BOOL_CHK_SYNC_IN_EN to pass fout_in through a 2-flop synchroniser.
module bool_response_checker
    import bool_chk_pkg::*;
#(
    parameter logic [31:0] EXPECTED_TT   = 32'h0000_0000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec_out,
    input  logic             fout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("bool_response_checker: SETTLE_CYCLES must be within 1..15");
    end

    logic fout_s;

`ifdef BOOL_CHK_SYNC_IN_EN
    // Two extra settle clocks cover the synchroniser latency.
    localparam int unsigned SETTLE_LAST = SETTLE_CYCLES + 1;

    bool_chk_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (fout_in),
        .q_o   (fout_s)
    );
`else
    localparam int unsigned SETTLE_LAST = SETTLE_CYCLES - 1;

    assign fout_s = fout_in;
`endif

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fev_q, fev_d;
    logic [VEC_W-1:0] fevec_q, fevec_d;
    logic             mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fevec_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevec_q <= fevec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fevec_d  = fevec_q;
        mismatch = fout_s != EXPECTED_TT[vec_q];

        case (state_q)
            APPLY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (!fev_q) begin
                        fev_d   = 1'b1;
                        fevec_d = vec_q;
                    end
                end
                if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_q == '0);
            end
            default: ;
        endcase

        // An accepted start overrides the idle/done hold and clears the results.
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d = APPLY;
            vec_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            fev_d   = 1'b0;
            fevec_d = '0;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fevec_q;

endmodule
